// File: rtl/in_out_allocator_pkg.sv
// params_noc: router port count and port identifiers shared by the allocator
package params_noc;
  localparam int in_Port_Cnt = 5;
  typedef enum logic [2:0] {LOCAL = 3'd0, NORTH = 3'd1, SOUTH = 3'd2, WEST = 3'd3, EAST = 3'd4} inout_Port;
endpackage

// File: rtl/in_out_allocator_round_robin_arbiter.sv
// round_robin_arbiter: one-hot round-robin pick; pointer moves past each winner
module round_robin_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] requests,
  output logic [N-1:0] grants
);
  localparam int W = $clog2(N);
  logic [W-1:0] ptr_q, ptr_d, win;
  logic any;
  int k;
  // scan from the pointer; descending loop leaves the nearest requester in win
  always_comb begin
    win = '0;
    any = 1'b0;
    k = 0;
    for (int n = N - 1; n >= 0; n--) begin
      k = int'(ptr_q) + n;
      if (k >= N) k = k - N;
      if (requests[k]) begin
        win = W'(k);
        any = 1'b1;
      end
    end
    grants = (any && !rst_n) ? N'(1) << win : '0;
    ptr_d = any ? ((win == W'(N - 1)) ? '0 : win + W'(1)) : ptr_q;
  end
  // pointer register, cleared while rst_n is high
  always_ff @(posedge clk) ptr_q <= rst_n ? '0 : ptr_d;
endmodule

// File: rtl/in_out_allocator.sv
// in_out_allocator: separable input-first VC/switch allocator; ALLOC_ASSERT_EN adds grant checks
import params_noc::*;
module in_out_allocator #(
  parameter int vc_Num = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [in_Port_Cnt-1:0][vc_Num-1:0] request_in,
  input  inout_Port                          inports_Out [in_Port_Cnt-1:0][vc_Num-1:0],
  output logic [in_Port_Cnt-1:0][vc_Num-1:0] grant_o
);
  logic [in_Port_Cnt-1:0][vc_Num-1:0] vc_grant;
  logic [in_Port_Cnt-1:0][in_Port_Cnt-1:0] out_req, ip_grant;
  logic [in_Port_Cnt-1:0] in_won;
  for (genvar g = 0; g < in_Port_Cnt; g++) begin : g_arb
    round_robin_arbiter #(.N(vc_Num)) u_vc (
      .clk(clk), .rst_n(rst_n), .requests(request_in[g]), .grants(vc_grant[g]));
    round_robin_arbiter #(.N(in_Port_Cnt)) u_ip (
      .clk(clk), .rst_n(rst_n), .requests(out_req[g]), .grants(ip_grant[g]));
  end
  // each stage-1 winner requests the output its VC is routed to
  always_comb begin
    out_req = '0;
    for (int i = 0; i < in_Port_Cnt; i++)
      for (int v = 0; v < vc_Num; v++)
        for (int o = 0; o < in_Port_Cnt; o++)
          if (vc_grant[i][v] && int'(inports_Out[i][v]) == o) out_req[o][i] = 1'b1;
  end
  // an input keeps its stage-1 VC only if some output picked it
  always_comb begin
    in_won = '0;
    for (int o = 0; o < in_Port_Cnt; o++)
      for (int i = 0; i < in_Port_Cnt; i++)
        in_won[i] = in_won[i] | ip_grant[o][i];
    for (int i = 0; i < in_Port_Cnt; i++)
      grant_o[i] = (in_won[i] && !rst_n) ? vc_grant[i] : '0;
  end
`ifdef ALLOC_ASSERT_EN
  logic [in_Port_Cnt-1:0][in_Port_Cnt-1:0] out_use;
  // which inputs hold a grant on each output
  always_comb begin
    out_use = '0;
    for (int i = 0; i < in_Port_Cnt; i++)
      for (int v = 0; v < vc_Num; v++)
        for (int o = 0; o < in_Port_Cnt; o++)
          if (grant_o[i][v] && int'(inports_Out[i][v]) == o) out_use[o][i] = 1'b1;
  end
  for (genvar g = 0; g < in_Port_Cnt; g++) begin : g_chk
    a_row_onehot: assert property (@(posedge clk) disable iff (rst_n) $onehot0(grant_o[g]))
      else $error("grant row %0d not one-hot", g);
    a_out_single: assert property (@(posedge clk) disable iff (rst_n) $onehot0(out_use[g]))
      else $error("output %0d granted to several inputs", g);
    a_req_backed: assert property (@(posedge clk) disable iff (rst_n) (grant_o[g] & ~request_in[g]) == '0)
      else $error("grant without request on input %0d", g);
  end
`endif
endmodule

// File: tb/tb_in_out_allocator.sv
// tb_in_out_allocator: directed vectors against hand-computed grant matrices
module tb_in_out_allocator;
  import params_noc::*;
  logic clk = 1'b0;
  logic rst_n;
  logic [in_Port_Cnt-1:0][3:0] request_in, grant_o;
  inout_Port inports_Out [in_Port_Cnt-1:0][3:0];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  in_out_allocator #(.vc_Num(4)) dut (
    .clk(clk), .rst_n(rst_n), .request_in(request_in), .inports_Out(inports_Out), .grant_o(grant_o));
  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [19:0] exp);
    #1;
    check(tag, grant_o, exp);
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    request_in = '0;
    for (int i = 0; i < in_Port_Cnt; i++)
      for (int v = 0; v < 4; v++) inports_Out[i][v] = LOCAL;
  endtask
  task automatic do_reset(input string tag);
    rst_n = 1'b1;
    clear();
    request_in[0] = 4'b1111;
    cyc(tag, 20'h0);
    rst_n = 1'b0;
    clear();
  endtask
  initial begin
    do_reset("reset");
    request_in[0] = 4'b0101;
    for (int v = 0; v < 4; v++) inports_Out[0][v] = EAST;
    cyc("rot_c1", 20'h00001);
    cyc("rot_c2", 20'h00004);
    cyc("rot_c3", 20'h00001);
    request_in = '0;
    cyc("idle_c1", 20'h0);
    cyc("idle_c2", 20'h0);
    cyc("idle_c3", 20'h0);
    request_in[0] = 4'b0101;
    cyc("resume_c1", 20'h00004);
    cyc("resume_c2", 20'h00001);
    do_reset("reset_cont");
    request_in[1] = 4'b0001;
    request_in[2] = 4'b0001;
    inports_Out[1][0] = NORTH;
    inports_Out[2][0] = NORTH;
    cyc("cont_c1", 20'h00010);
    cyc("cont_c2", 20'h00100);
    do_reset("reset_adv");
    request_in[1] = 4'b0001;
    request_in[2] = 4'b0011;
    inports_Out[1][0] = NORTH;
    inports_Out[2][0] = NORTH;
    inports_Out[2][1] = SOUTH;
    cyc("adv_c1", 20'h00010);
    cyc("adv_c2", 20'h00210);
    do_reset("reset_noconf");
    for (int i = 0; i < in_Port_Cnt; i++) begin
      request_in[i] = 4'b1000;
      inports_Out[i][3] = inout_Port'(i);
    end
    cyc("noconf", 20'h88888);
    do_reset("reset_mid");
    request_in[1] = 4'b0011;
    request_in[2] = 4'b0011;
    for (int v = 0; v < 2; v++) begin
      inports_Out[1][v] = NORTH;
      inports_Out[2][v] = NORTH;
    end
    cyc("mid_c1", 20'h00010);
    rst_n = 1'b1;
    cyc("mid_rst", 20'h0);
    rst_n = 1'b0;
    cyc("mid_after", 20'h00010);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/in_out_allocator.md
Name: in_out_allocator

Overview:
- Separable, input-first switch allocator for a 5-port NoC router with virtual channels.
- Stage 1: each input port picks one requesting VC by round-robin.
- Stage 2: each output port picks one input among those whose stage-1 winner targets it, also by round-robin.
- Output is a per-input, per-VC grant matrix consumed by the crossbar and VC buffers.

Parameters:
- vc_Num, 4, number of virtual channels per input port (>=2).
- in_Port_Cnt, 5 (package constant, not a module parameter), number of router ports.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-high.
- request_in  input  [in_Port_Cnt-1:0][vc_Num-1:0]  request_in[i][v]=1: VC v of input i requests the switch.
- inports_Out  input  unpacked [in_Port_Cnt-1:0] of inout_Port[vc_Num-1:0]  output port targeted by VC v of input i.
- grant_o  output  [in_Port_Cnt-1:0][vc_Num-1:0]  grant_o[i][v]=1: VC v of input i wins switch traversal this cycle.

Behaviour:
- grant_o is combinational from request_in, inports_Out and the current priority pointers; it is valid in the same cycle.
- State:
  - vc_ptr[i], $clog2(vc_Num) bits, one per input.
  - ip_ptr[o], $clog2(in_Port_Cnt) bits, one per output.
- Reset (rst_n=1 at a rising edge): all pointers go to 0. grant_o is forced to all zeros while rst_n=1.
- Stage 1, per input i:
  - Scan VCs (vc_ptr[i]+n) mod vc_Num for n=0..vc_Num-1; the first set request wins. vc_grant[i] is one-hot or zero.
- Stage-1 request fan-out:
  - out_req[o][i]=1 iff input i has a stage-1 winner v and inports_Out[i][v]==o.
  - At most one request per input.
- Stage 2, per output o:
  - Scan inputs (ip_ptr[o]+n) mod in_Port_Cnt; the first set out_req[o][i] wins, giving ip_grant[o][i].
- Final grant: grant_o[i][v] = vc_grant[i][v] AND (OR over o of ip_grant[o][i]).
  - At most one VC per input and one input per output.
- Pointer update, at each rising edge with rst_n=0:
  - vc_ptr[i] <= (winner VC + 1) mod vc_Num whenever input i has any stage-1 winner, even if that input loses stage 2.
  - ip_ptr[o] <= (winning input + 1) mod in_Port_Cnt whenever output o grants.
  - Otherwise each pointer holds.
- Wrap-around: a winner at the last index sets the pointer to 0.
- No requests anywhere: grant_o=0 and all pointers hold.
- Reset asserted mid-operation: grants suppress in that cycle; the next arbitration starts from pointers at 0.

Optional Feature:
- Macro ALLOC_ASSERT_EN.
- When defined, concurrent assertions (disabled during reset) check each cycle that:
  - each row grant_o[i] is one-hot or zero;
  - no output port is granted to more than one input;
  - every grant corresponds to a set request_in bit.
- Violations report via $error.
- Without the macro, no assertion code is compiled and function is identical.

Decomposition:
- Package params_noc holds:
  - in_Port_Cnt=5;
  - typedef enum logic [2:0] inout_Port {LOCAL=0, NORTH=1, SOUTH=2, WEST=3, EAST=4}.
- One sub-module, round_robin_arbiter #(N):
  - ports clk, rst_n, requests[N], grants[N] (one-hot, combinational);
  - internal pointer register with the update rule above.
- Instantiate it in_Port_Cnt times with N=vc_Num for stage 1, and in_Port_Cnt times with N=in_Port_Cnt for stage 2.

Test Plan:
- Single input VC rotation: after reset, input 0 request_in[0]=4'b0101, all VCs to EAST, other inputs idle. Over 3 consecutive cycles grant_o[0] is 0001, 0100, 0001; all other rows 0.
- Output contention: input 1 req 0001 and input 2 req 0001, both VC0→NORTH. Cycle 1: grant_o[1]=0001, grant_o[2]=0000. Cycle 2: grant_o[1]=0000, grant_o[2]=0001.
- Stage-1 pointer advance despite stage-2 loss: input 2 req 0011, VC0→NORTH, VC1→SOUTH, competing with input 1 on NORTH. Cycle 1: input 2 loses. Cycle 2: input 2 gets grant_o[2]=0010 on SOUTH.
- No conflict: every input requests 1000 with VC3 routed to distinct ports (LOCAL, NORTH, SOUTH, WEST, EAST). Every row of grant_o is 1000 in the same cycle.
- Idle/hold: all request_in=0 for 3 cycles, then resume the first scenario. grant_o=0 while idle, and the rotation continues from the pre-idle pointer.
- Mid-run reset: assert rst_n for 1 cycle during contention. grant_o=0 that cycle; afterwards VC0 and input-index-lowest priority are restored (pointers at 0).
